// File: rtl/sfifo_mux_if.sv
// WISHBONE slave front-end multiplexing NCH first-word-fall-through sync FIFOs plus a base-period tick.
// Latency: strobe sampled at edge N -> ack (and pop for data reads) in cycle N+1; back-to-back accesses take 2 cycles each.
// Backpressure: a data read of an empty channel withholds ack until data arrives or the master drops cyc/stb
//   (with SFIFO_MUX_IF_TMO_EN: or until the timeout expires).
//
// Ports:
//   wb_clk_i, wb_rst_i     clock and synchronous active-high reset
//   wb_cyc_i .. wb_dat_o   WISHBONE slave port (wb_sel_i ignored, full-word accesses)
//   wb_ack_o               one-cycle acknowledge
//   sfifo_rd_o             per-channel pop strobe (one-hot, one cycle per popped word)
//   sfifo_empty_i          per-channel empty flags
//   sfifo_di               packed head words, channel c at [c*SFIFO_DW +: SFIFO_DW]
//   sfifo_bp_tick_i        base-period tick level
//
// Word map (word offset = wb_adr_i[WB_LAW-1:2]):
//   0 BP_TICK  {0,flag}, read clears      1 EMPTY    {0,sfifo_empty_i}
//   2 BP_CNT   {0,cnt}, any write clears  3 TMO_STAT {0,sticky}, write-1-to-clear
//   8..8+NCH-1 head word of channel off-8, read pops; anything else reads 0
//
// Optional macro SFIFO_MUX_IF_TMO_EN: a data read stalled for 2**TMO_W-1 WAIT cycles
// completes with bit WB_DW-1 set, zero data, no pop, and sets TMO_STAT[channel].

module sfifo_mux_if #(
    parameter int WB_LAW   = 6,
    parameter int WB_DW    = 32,
    parameter int SFIFO_DW = 16,
    parameter int NCH      = 4,
    parameter int TMO_W    = 8
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [3:0]              wb_sel_i,
    input  logic [WB_LAW-1:0]       wb_adr_i,
    input  logic [WB_DW-1:0]        wb_dat_i,
    output logic [WB_DW-1:0]        wb_dat_o,
    output logic                    wb_ack_o,
    output logic [NCH-1:0]          sfifo_rd_o,
    input  logic [NCH-1:0]          sfifo_empty_i,
    input  logic [NCH*SFIFO_DW-1:0] sfifo_di,
    input  logic                    sfifo_bp_tick_i
);

    localparam int OFF_W = WB_LAW - 2;
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

    if (SFIFO_DW > WB_DW - 1 || NCH < 1 || NCH > 8 || TMO_W < 1 || WB_LAW < 6) begin : g_param_check
        $error("sfifo_mux_if: unsupported parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t            state_q, state_d;
    logic [WB_DW-1:0]  dat_q, dat_d;
    logic [NCH-1:0]    rd_q, rd_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              tick_q;
    logic              flag_q, flag_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              flag_clr, cnt_clr;

    logic [SFIFO_DW-1:0] head [NCH];
    for (genvar c = 0; c < NCH; c++) begin : g_head
        assign head[c] = sfifo_di[c*SFIFO_DW +: SFIFO_DW];
    end

    logic [OFF_W-1:0] off;
    logic [CH_W-1:0]  ch;
    logic             req, is_di, tick_edge;

    assign off       = wb_adr_i[WB_LAW-1:2];
    // DI window starts at 8, so the channel index is simply the low offset bits.
    assign ch        = off[CH_W-1:0];
    assign req       = wb_cyc_i & wb_stb_i;
    // One extra bit so that 8+NCH (up to 16) does not wrap for a 4-bit offset.
    assign is_di     = ({1'b0, off} >= (OFF_W+1)'(8)) && ({1'b0, off} < (OFF_W+1)'(8 + NCH));
    assign tick_edge = sfifo_bp_tick_i & ~tick_q;

`ifdef SFIFO_MUX_IF_TMO_EN
    logic [TMO_W-1:0] tmo_q, tmo_d, tmo_nxt;
    logic [NCH-1:0]   sticky_q, sticky_d;
    assign tmo_nxt = tmo_q + 1'b1;
    logic unused_ok;
    assign unused_ok = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i[WB_DW-1:NCH]};
`else
    logic unused_ok;
    assign unused_ok = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};
`endif

    always_comb begin
        state_d  = state_q;
        dat_d    = dat_q;
        rd_d     = '0;
        ch_d     = ch_q;
        flag_clr = 1'b0;
        cnt_clr  = 1'b0;
`ifdef SFIFO_MUX_IF_TMO_EN
        tmo_d    = tmo_q;
        sticky_d = sticky_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (is_di && !wb_we_i) begin
                        ch_d = ch;
                        if (!sfifo_empty_i[ch]) begin
                            state_d  = S_ACK;
                            rd_d[ch] = 1'b1;
                            dat_d    = WB_DW'(head[ch]);
                        end else begin
                            state_d = S_WAIT;
`ifdef SFIFO_MUX_IF_TMO_EN
                            tmo_d   = '0;
`endif
                        end
                    end else begin
                        // Register accesses and all writes complete in one step.
                        state_d = S_ACK;
                        dat_d   = '0;
                        case (off)
                            OFF_W'(0): if (!wb_we_i) begin
                                dat_d    = WB_DW'(flag_q);
                                flag_clr = 1'b1;
                            end
                            OFF_W'(1): if (!wb_we_i) dat_d = WB_DW'(sfifo_empty_i);
                            OFF_W'(2): if (wb_we_i) cnt_clr = 1'b1;
                                       else         dat_d   = WB_DW'(cnt_q);
`ifdef SFIFO_MUX_IF_TMO_EN
                            OFF_W'(3): if (wb_we_i) sticky_d = sticky_q & ~wb_dat_i[NCH-1:0];
                                       else         dat_d    = WB_DW'(sticky_q);
`endif
                            default: ;
                        endcase
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (!sfifo_empty_i[ch_q]) begin
                    // Data arriving always beats the timeout, even on its terminal cycle.
                    state_d    = S_ACK;
                    rd_d[ch_q] = 1'b1;
                    dat_d      = WB_DW'(head[ch_q]);
`ifdef SFIFO_MUX_IF_TMO_EN
                end else if (tmo_nxt == '1) begin
                    // Counter reaches 2**TMO_W-1 after that many WAIT cycles: give up.
                    state_d          = S_ACK;
                    dat_d            = '0;
                    dat_d[WB_DW-1]   = 1'b1;
                    sticky_d[ch_q]   = 1'b1;
                end else begin
                    tmo_d = tmo_nxt;
`endif
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A tick edge wins over a coincident clear: flag ends at 1, count at 1.
    always_comb begin
        flag_d = flag_q;
        cnt_d  = cnt_q;
        if (tick_edge) begin
            flag_d = 1'b1;
            if (cnt_clr)                cnt_d = 16'd1;
            else if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end else begin
            if (flag_clr) flag_d = 1'b0;
            if (cnt_clr)  cnt_d  = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            dat_q   <= '0;
            rd_q    <= '0;
            ch_q    <= '0;
            tick_q  <= 1'b0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            rd_q    <= rd_d;
            ch_q    <= ch_d;
            tick_q  <= sfifo_bp_tick_i;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SFIFO_MUX_IF_TMO_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tmo_q    <= '0;
            sticky_q <= '0;
        end else begin
            tmo_q    <= tmo_d;
            sticky_q <= sticky_d;
        end
    end
`endif

    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = (state_q == S_ACK);
    assign sfifo_rd_o = rd_q;

endmodule
